// File: rtl/ifmap_buffer_ctrl.sv
// Fills the 128x8 ifmap SRAM from an input stream, then drains it in order; first out_valid 3 cycles after last fill beat.
// Downstream stalls are absorbed by a 2-entry skid buffer; optional IFMAP_REPLAY_EN repeats the drain pass replay_cnt+1 times.
module ifmap_buffer_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
`ifdef IFMAP_REPLAY_EN
  input  logic [3:0]        replay_cnt,
`endif
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE     = 1;

  state_t state, next_state;

  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_m1;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              start_ok;
  logic              wr_en;
  logic              rd_en;
  logic              rd_at_end;
  logic              final_pass;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        occ;
  logic [1:0]        pending;
  logic              room;
  logic              out_hs;
  logic              skid_wr;
  logic              skid_rd;
  logic [DATA_W-1:0] skid_dat [2];
  logic              skid_last [2];

`ifdef IFMAP_REPLAY_EN
  logic [3:0] rep;
  logic [3:0] pass;
  assign final_pass = (pass == rep);
`else
  assign final_pass = 1'b1;
`endif

  assign start_ok  = start && (frame_len != '0);
  assign len_m1    = len - ONE;
  assign rd_at_end = (rd_ptr == len_m1);
  assign pending   = occ + {1'b0, inflight};
  assign room      = (pending < 2'd2);

  assign busy      = (state != IDLE);
  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? skid_dat[skid_rd] : '0;
  assign out_last  = out_valid && skid_last[skid_rd];
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_oeb   = 1'b1;
    sram_a     = '0;
    sram_i     = '0;
    case (state)
      IDLE: begin
        if (start_ok) next_state = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en    = 1'b1;
          sram_csb = 1'b0;
          sram_web = 1'b0;
          sram_a   = wr_ptr[ADDR_W-1:0];
          sram_i   = in_data;
          if (wr_ptr == len_m1) next_state = DRAIN;
        end
      end
      DRAIN: begin
        sram_oeb = 1'b0;
        // A same-cycle pop frees a slot, which keeps the stream bubble-free.
        if ((rd_ptr < len) && (room || out_hs)) begin
          rd_en    = 1'b1;
          sram_csb = 1'b0;
          sram_a   = rd_ptr[ADDR_W-1:0];
        end
        if (out_hs && out_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      done          <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
`ifdef IFMAP_REPLAY_EN
      rep           <= '0;
      pass          <= '0;
`endif
    end else begin
      done          <= (state == DRAIN) && out_hs && out_last;
      inflight      <= rd_en;
      inflight_last <= rd_en && rd_at_end && final_pass;
      if ((state == IDLE) && start_ok) begin
        len    <= (frame_len > DEPTH_L) ? DEPTH_L : frame_len;
        wr_ptr <= '0;
        rd_ptr <= '0;
`ifdef IFMAP_REPLAY_EN
        rep    <= replay_cnt;
        pass   <= '0;
`endif
      end
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) begin
`ifdef IFMAP_REPLAY_EN
        if (rd_at_end && !final_pass) begin
          rd_ptr <= '0;
          pass   <= pass + 4'd1;
        end else begin
          rd_ptr <= rd_ptr + ONE;
        end
`else
        rd_ptr <= rd_ptr + ONE;
`endif
      end
    end
  end

  // Skid buffer: SRAM data lands one cycle after issue, popped in FIFO order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ          <= '0;
      skid_wr      <= 1'b0;
      skid_rd      <= 1'b0;
      skid_dat[0]  <= '0;
      skid_dat[1]  <= '0;
      skid_last[0] <= 1'b0;
      skid_last[1] <= 1'b0;
    end else begin
      if (inflight) begin
        skid_dat[skid_wr]  <= sram_o;
        skid_last[skid_wr] <= inflight_last;
        skid_wr            <= ~skid_wr;
      end
      if (out_hs) skid_rd <= ~skid_rd;
      occ <= occ + {1'b0, inflight} - {1'b0, out_hs};
    end
  end

endmodule

// File: doc/ifmap_buffer_ctrl.md
Name: ifmap_buffer_ctrl

Overview:
- Controller wrapped around the 128x8 single-port ifmap SRAM macro.
- Fill phase: accepts a frame of ifmap bytes on a valid/ready stream and writes them into the SRAM at ascending addresses.
- Drain phase: reads the frame back in order and presents it to the downstream compute array on a valid/ready stream.
- Absorbs the macro's one-cycle read latency with a 2-entry output skid buffer.

Parameters:
- DATA_W, 8: word width; matches the SRAM word.
- ADDR_W, 7: SRAM address width.
- DEPTH, 128: SRAM words; maximum frame length.

Ports:
- clk  in  1  clock; also drives the SRAM CE pin.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- frame_len  in  ADDR_W+1  frame length in words; latched on accepted start.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last drain handshake.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  high only in FILL.
- in_data  in  DATA_W  upstream byte.
- out_valid  out  1  downstream byte valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  downstream byte.
- out_last  out  1  qualifies the final byte of the frame.
- sram_a  out  ADDR_W  SRAM address.
- sram_csb  out  1  SRAM chip select, active low.
- sram_web  out  1  SRAM write enable, active low.
- sram_oeb  out  1  SRAM output enable, active low.
- sram_i  out  DATA_W  SRAM write data.
- sram_o  in  DATA_W  SRAM read data; valid the cycle after a read is issued.

Behaviour:
- Reset (async, rst=1) forces:
  - state IDLE; all counters and skid entries 0.
  - busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_data=0.
  - sram_csb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_i=0.
  - SRAM contents are not cleared.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - start=1 with frame_len>=1 latches len = min(frame_len, DEPTH), clears wr_ptr and rd_ptr, then enters FILL next cycle.
  - start with frame_len=0 is ignored: no busy, no done.
- FILL:
  - in_ready=1.
  - On an in_valid&&in_ready cycle, drive combinationally: sram_csb=0, sram_web=0, sram_a=wr_ptr, sram_i=in_data. The write occurs at that clock edge, and wr_ptr increments.
  - Non-handshake cycles: sram_csb=1.
  - After the len-th write, go to DRAIN next cycle; in_ready=0 from then on.
- DRAIN:
  - sram_oeb=0 throughout DRAIN.
  - Read issue condition: rd_ptr<len AND (occupancy + inflight < 2 OR an out handshake occurs this cycle).
  - On issue, drive sram_csb=0, sram_web=1, sram_a=rd_ptr; rd_ptr increments.
  - sram_o is captured into the skid buffer at the end of the following cycle.
  - Ordering is strictly FIFO.
  - out_valid is high whenever the skid buffer is non-empty.
  - out_data and out_last hold stable while out_valid&&!out_ready.
  - out_last=1 on the entry read from address len-1.
- Latency and throughput:
  - Last fill handshake in cycle T gives the first read issue at T+1 and out_valid=1 at T+3.
  - With out_ready held high, output is one byte per cycle with no bubbles.
- Completion: on the out_last handshake, done pulses in the next cycle, the state returns to IDLE, busy=0, and sram_csb=1.
- start while busy is ignored.
- Address increment never wraps past len-1; len=DEPTH uses addresses 0..DEPTH-1.
- No simultaneous read and write: FILL issues only writes, DRAIN only reads.
- Reset mid-operation aborts the frame immediately; in-flight data is discarded.

Optional Feature:
- Macro: IFMAP_REPLAY_EN.
- Defined:
  - Adds input replay_cnt [3:0], latched on start.
  - DRAIN runs replay_cnt+1 passes over addresses 0..len-1 without refilling.
  - out_last asserts only on the final byte of the final pass.
  - Issue and throughput continue across pass boundaries with no bubble.
  - done pulses once, after the final pass.
- Undefined: no replay_cnt port; exactly one drain pass.

Test Plan:
- Short frame: frame_len=4, bytes 0x11,0x22,0x33,0x44, out_ready=1 -> SRAM writes to addresses 0..3; output 0x11,0x22,0x33,0x44 with out_last only on 0x44; single done pulse; busy low afterwards.
- Full frame: frame_len=128, data=address, out_ready=1 -> 128 outputs back-to-back starting at T+3; values 0x00..0x7F; out_last on 0x7F.
- Backpressure: frame_len=16, out_ready follows pattern 1,0,0,1,0,1,1,0 repeating -> all 16 values delivered in order, none lost or duplicated; out_data stable on every stalled cycle.
- Boundaries: frame_len=0 -> busy stays 0 and no SRAM access; frame_len=200 -> clamped, exactly 128 writes and 128 outputs; start pulsed mid-FILL -> ignored.
- Reset mid-DRAIN: assert rst after the 10th output handshake -> all outputs at reset values while rst=1 (before the next edge); new frame_len=3 frame then completes correctly.
- IFMAP_REPLAY_EN: len=3 with data A,B,C, replay_cnt=2 -> output A,B,C,A,B,C,A,B,C; out_last only on the 9th byte; one done pulse.
